// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port word memory behind a valid/ready request/response handshake.
// One request is in flight at a time. An accepted request is held for a
// fixed LATENCY cycles, then committed (load read / store write) and the
// result is presented until the requester consumes it.
//
// FSM:  IDLE --req_valid--> BUSY --counter==0--> RESP --resp_ready--> IDLE
//
// Parameters
//   MEM_DEPTH  number of 32-bit words stored (default 256)
//   LATENCY    cycles from acceptance edge to commit edge, legal 1..15
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       asynchronous active-high reset; clears state, latched
//               request, response registers and every memory word
//   req_valid   requester presents a request (sampled only in IDLE)
//   req_ready   high only in IDLE
//   req_write   1 = store, 0 = load
//   req_addr    byte address; word index is req_addr[31:2]
//   req_din     store data
//   resp_valid  high only in RESP
//   resp_ready  requester consumes the response this cycle
//   resp_dout   load data; 0 for stores and errors
//   resp_err    request was misaligned or beyond MEM_DEPTH
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_din,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_dout,
    output logic        resp_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // The counter is loaded with LATENCY-1 at acceptance so that, counting
    // the acceptance edge as edge 0, it reaches zero in BUSY exactly in the
    // cycle before edge LATENCY; the commit happens on that edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_din;

    logic             accept;
    logic             commit;
    logic             lat_err;
    logic             wr_en;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      mem_rd [MEM_DEPTH];

    // -------------------------------------------------------------------------
    // Address check: misaligned byte address or word index past the end.
    // The index is widened so the compare also works for huge addresses.
    // -------------------------------------------------------------------------
    function automatic logic addr_error(input logic [31:0] addr);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= 32'(MEM_DEPTH));
    endfunction

    // Response data for a committed access: only an error-free load returns
    // memory contents.
    function automatic logic [31:0] load_value(input logic        is_write,
                                               input logic        is_err,
                                               input logic [31:0] word);
        return (is_write || is_err) ? 32'h0 : word;
    endfunction

    assign accept  = (state == IDLE) && req_valid;
    assign commit  = (state == BUSY) && (cnt == 4'd0);
    assign lat_err = addr_error(lat_addr);
    assign lat_idx = lat_addr[IDX_W+1:2];
    assign wr_en   = commit && lat_write && !lat_err;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // RESP never falls straight through to accepting a new request; the
    // requester always sees at least one IDLE cycle after consuming.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded from state only
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Latency counter; saturates at zero instead of wrapping.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch: captured only at acceptance, so input activity while
    // BUSY or RESP cannot disturb the access in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_addr  <= 32'h0;
            lat_din   <= 32'h0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_din   <= req_din;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers: loaded at the commit edge and held through RESP
    // (and beyond, until the next commit).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_dout <= 32'h0;
            resp_err  <= 1'b0;
        end else if (commit) begin
            resp_err  <= lat_err;
            resp_dout <= load_value(lat_write, lat_err, lat_err ? 32'h0 : mem_rd[lat_idx]);
        end
    end

    // -------------------------------------------------------------------------
    // Word storage. Each word is its own register with asynchronous clear so
    // that reset wipes the whole array at once, including any store that is
    // still waiting for its commit edge.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_word
        logic [31:0] word;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                word <= 32'h0;
            end else if (wr_en && (lat_idx == IDX_W'(g))) begin
                word <= lat_din;
            end
        end

        assign mem_rd[g] = word;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 4: cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 req_din  input  32  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  requester consumes the response this cycle.
REQ-012 resp_dout  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP; both are combinational from state.
REQ-016 Acceptance SHALL occur on an edge where req_valid=1 in IDLE: latch req_write, req_addr, req_din; load the latency counter; go to BUSY.
REQ-017 req_valid and all request inputs SHALL be ignored outside IDLE; latched values SHALL not change until the next acceptance.
REQ-018 Counting the acceptance edge as edge 0, the access SHALL commit at edge LATENCY and the FSM SHALL enter RESP at that edge.
REQ-019 For LATENCY=1, the FSM SHALL spend exactly one cycle in BUSY.
REQ-020 Load: resp_dout SHALL equal the word at the latched index, sampled at the commit edge.
REQ-021 Store: the word at the latched index SHALL be written with the latched data at the commit edge; resp_dout SHALL be 0.
REQ-022 Error: if latched addr[1:0] != 0 or index >= MEM_DEPTH, then resp_err=1, resp_dout=0, no memory write, and latency is unchanged.
REQ-023 resp_dout and resp_err SHALL be held stable throughout RESP.
REQ-024 In RESP with resp_ready=1, the FSM SHALL return to IDLE at the next edge; with resp_ready=0, it SHALL remain in RESP indefinitely.
REQ-025 Minimum spacing between acceptances SHALL be LATENCY+2 cycles: a request cannot be accepted in the same cycle a response is consumed.
REQ-026 A load issued after a store to the same index SHALL return the stored value.
REQ-027 The latency counter SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-028 While reset=1: state=IDLE, req_ready=1, resp_valid=0, resp_dout=0, resp_err=0, counter=0, latched request=0, and all memory words=0; this takes effect immediately, without waiting for clk.
REQ-029 Reset asserted in BUSY or RESP SHALL discard the pending request; a pending store not yet committed SHALL NOT be written.
REQ-030 After reset deassertion, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-031 LATENCY=4, store addr 0x10 data 0xDEADBEEF accepted at edge 0 -> resp_valid rises after edge 4, resp_dout=0, resp_err=0; then load addr 0x10 -> resp_dout=0xDEADBEEF after 4 cycles.
REQ-032 Load addr 0x13 -> resp_err=1, resp_dout=0; load addr 0x400 with MEM_DEPTH=256 -> resp_err=1, and memory is unmodified.
REQ-033 Hold resp_ready=0 for 10 cycles in RESP -> resp_valid stays 1, resp_dout stays stable, req_ready stays 0, and a req_valid pulse is ignored.
REQ-034 Assert reset at edge 2 of a store to 0x20 with data 0x5 -> outputs return to reset values immediately; a later load of 0x20 returns 0.
REQ-035 LATENCY=1, back-to-back requests with resp_ready=1 tied high -> accept every 3rd cycle, each response valid for exactly 1 cycle.
REQ-036 Random request stream checked against a reference word array -> all resp_dout and resp_err values match, and every latency equals LATENCY.
